// File: rtl/key_debounce.sv
// Two-key debouncer with press/release/long-press pulses; all outputs registered.
// Press/release latency is DEB_MAX+2 edges from the first differing raw sample.
module key_debounce #(
  parameter logic [25:0] DEB_MAX  = 26'd1000000,
  parameter logic [25:0] LONG_MAX = 26'd50000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] key,
  output logic [1:0] key_value,
  output logic [1:0] key_press,
  output logic [1:0] key_release,
  output logic [1:0] key_long
);

  localparam logic [25:0] DEB_LAST  = DEB_MAX - 26'd1;
  localparam logic [25:0] LONG_LAST = LONG_MAX - 26'd1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILTER,
    HELD,
    RELEASE_FILTER
  } state_t;

  logic [1:0]  r_s1;
  logic [1:0]  r_s2;
  state_t      r_state    [2];
  logic [25:0] r_filt_cnt [2];
  logic [25:0] r_hold_cnt [2];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_s1 <= 2'b11;
      r_s2 <= 2'b11;
    end else begin
      r_s1 <= key;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_value   <= 2'b11;
      key_press   <= 2'b00;
      key_release <= 2'b00;
      key_long    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_state[i]    <= IDLE;
        r_filt_cnt[i] <= '0;
        r_hold_cnt[i] <= '0;
      end
    end else begin
      key_press   <= 2'b00;
      key_release <= 2'b00;
      key_long    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        // Hold timer runs across release bounces; saturates at LONG_MAX so it fires once.
        if (r_state[i] == HELD || r_state[i] == RELEASE_FILTER) begin
          if (r_hold_cnt[i] == LONG_LAST) begin
            key_long[i]   <= 1'b1;
            r_hold_cnt[i] <= LONG_MAX;
          end else if (r_hold_cnt[i] != LONG_MAX) begin
            r_hold_cnt[i] <= r_hold_cnt[i] + 26'd1;
          end
        end

        case (r_state[i])
          IDLE: begin
            if (!r_s2[i]) begin
              r_state[i]    <= PRESS_FILTER;
              r_filt_cnt[i] <= 26'd1;
            end
          end
          PRESS_FILTER: begin
            if (r_s2[i]) begin
              r_state[i]    <= IDLE;
              r_filt_cnt[i] <= '0;
            end else if (r_filt_cnt[i] == DEB_LAST) begin
              r_state[i]    <= HELD;
              r_filt_cnt[i] <= '0;
              r_hold_cnt[i] <= '0;
              key_value[i]  <= 1'b0;
              key_press[i]  <= 1'b1;
            end else begin
              r_filt_cnt[i] <= r_filt_cnt[i] + 26'd1;
            end
          end
          HELD: begin
            if (r_s2[i]) begin
              r_state[i]    <= RELEASE_FILTER;
              r_filt_cnt[i] <= 26'd1;
            end
          end
          RELEASE_FILTER: begin
            if (!r_s2[i]) begin
              r_state[i]    <= HELD;
              r_filt_cnt[i] <= '0;
            end else if (r_filt_cnt[i] == DEB_LAST) begin
              // Release wins over a coincident long-press pulse.
              r_state[i]     <= IDLE;
              r_filt_cnt[i]  <= '0;
              r_hold_cnt[i]  <= '0;
              key_value[i]   <= 1'b1;
              key_release[i] <= 1'b1;
              key_long[i]    <= 1'b0;
            end else begin
              r_filt_cnt[i] <= r_filt_cnt[i] + 26'd1;
            end
          end
          default: r_state[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEB_MAX=4, LONG_MAX=20: vector table, directed corner sequences, random run vs. model.
module tb_key_debounce;

  localparam int DEB = 4;
  localparam int LNG = 20;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] key;
  logic [1:0] key_value, key_press, key_release, key_long;

  key_debounce #(.DEB_MAX(26'(DEB)), .LONG_MAX(26'(LNG))) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key        (key),
    .key_value  (key_value),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  // Reference: debounced level flips once DEB consecutive synchronised samples disagree with it.
  logic [1:0] m_pipe0, m_pipe1, m_lvl, m_press, m_rel, m_long;
  int         m_run [2];
  int         m_age [2];

  typedef struct {
    logic [1:0] k;
    logic       r;
    logic [1:0] val;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got val/prs/rel/lng=%b_%b_%b_%b want %b_%b_%b_%b", name, $time,
               act[7:6], act[5:4], act[3:2], act[1:0], exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  function automatic logic [7:0] outs();
    return {key_value, key_press, key_release, key_long};
  endfunction

  task automatic model_step(input logic [1:0] k, input logic r);
    m_press = 2'b00;
    m_rel   = 2'b00;
    m_long  = 2'b00;
    if (r) begin
      m_pipe0 = 2'b11;
      m_pipe1 = 2'b11;
      m_lvl   = 2'b11;
      for (int b = 0; b < 2; b++) begin
        m_run[b] = 0;
        m_age[b] = 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        logic was_down;
        was_down = (m_lvl[b] == 1'b0);
        if (was_down) m_age[b]++;
        if (m_pipe1[b] != m_lvl[b]) m_run[b]++;
        else m_run[b] = 0;
        if (m_run[b] == DEB) begin
          m_lvl[b] = ~m_lvl[b];
          m_run[b] = 0;
          if (!m_lvl[b]) begin
            m_press[b] = 1'b1;
            m_age[b]   = 0;
          end else begin
            m_rel[b] = 1'b1;
          end
        end
        if (was_down && !m_rel[b] && m_age[b] == LNG) m_long[b] = 1'b1;
      end
      m_pipe1 = m_pipe0;
      m_pipe0 = k;
    end
  endtask

  task automatic tick(input logic [1:0] k, input logic r);
    key     = k;
    sys_rst = r;
    @(posedge sys_clk);
    model_step(k, r);
    #1;
    chk("model", outs(), {m_lvl, m_press, m_rel, m_long});
  endtask

  function automatic void add(input logic [1:0] k, input logic r, input logic [1:0] val,
                              input logic [1:0] prs, input logic [1:0] rel, input logic [1:0] lng);
    vec_t v;
    v.k = k; v.r = r; v.val = val; v.prs = prs; v.rel = rel; v.lng = lng;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [1:0] rk;
    logic       rr;
    int         idx;
    logic [1:0] kk;

    key     = 2'b11;
    sys_rst = 1'b1;

    // Reset, clean press on key[0], its release, then simultaneous press on both.
    add(2'b11, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int i = 1; i <= 5; i++) add(2'b10, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b10, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
    add(2'b10, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
    for (int i = 1; i <= 5; i++) add(2'b11, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00);
    add(2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int i = 1; i <= 5; i++) add(2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00);
    add(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

    foreach (tbl[i]) begin
      tick(tbl[i].k, tbl[i].r);
      chk($sformatf("vec%0d", i), outs(), {tbl[i].val, tbl[i].prs, tbl[i].rel, tbl[i].lng});
    end

    // Bounce on key[0]: low 3, high 1, then low; one press 6 edges after the last fall.
    tick(2'b11, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      kk = (i == 4) ? 2'b11 : 2'b10;
      tick(kk, 1'b0);
      chk($sformatf("bounce%0d", i), outs(),
          {(i >= 10) ? 2'b10 : 2'b11, (i == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00});
    end

    // Long press on key[1], then release.
    tick(2'b11, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      tick(2'b01, 1'b0);
      chk($sformatf("long%0d", i), outs(),
          {(i >= 6) ? 2'b01 : 2'b11, (i == 6) ? 2'b10 : 2'b00, 2'b00, (i == 26) ? 2'b10 : 2'b00});
    end
    for (int j = 1; j <= 8; j++) begin
      tick(2'b11, 1'b0);
      chk($sformatf("long_rel%0d", j), outs(),
          {(j >= 6) ? 2'b11 : 2'b01, 2'b00, (j == 6) ? 2'b10 : 2'b00, 2'b00});
    end

    // Short release glitch while held on key[0]: no release, long still on time.
    tick(2'b11, 1'b1);
    for (int i = 1; i <= 30; i++) begin
      kk = (i == 10 || i == 11) ? 2'b11 : 2'b10;
      tick(kk, 1'b0);
      chk($sformatf("glitch%0d", i), outs(),
          {(i >= 6) ? 2'b10 : 2'b11, (i == 6) ? 2'b01 : 2'b00, 2'b00, (i == 26) ? 2'b01 : 2'b00});
    end

    // Reset while held: no release, then re-filtered press.
    tick(2'b10, 1'b1);
    chk("rst_midhold", outs(), {2'b11, 2'b00, 2'b00, 2'b00});
    for (int i = 1; i <= 8; i++) begin
      tick(2'b10, 1'b0);
      chk($sformatf("rst_repress%0d", i), outs(),
          {(i >= 6) ? 2'b10 : 2'b11, (i == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00});
    end

    // Random run against the model: fast toggling then slow toggling for long holds.
    tick(2'b11, 1'b1);
    rk = 2'b11;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, (n < 2000) ? 5 : 30) == 0) begin
        idx = $urandom_range(0, 1);
        rk[idx] = ~rk[idx];
      end
      if ($urandom_range(0, 2) == 0) rk = rk;
      rr = ($urandom_range(0, 499) == 0);
      tick(rk, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
